// File: rtl/balanca_ctrl.sv
// Price datapath sequencer for the scale: tare subtract, shift-add multiply, restoring
// divide by 1000 with half-up rounding, clamp, and double-dabble to packed BCD for the display.
module balanca_ctrl #(
   parameter int unsigned W_PESO  = 20,
   parameter int unsigned W_PRECO = 16,
   parameter int unsigned DIGITS  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [W_PESO-1:0]     peso_g,
   input  logic [W_PRECO-1:0]    preco_kg,
   input  logic                  tara_btn,
   input  logic                  start,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   saida_peso,
   output logic [4*DIGITS-1:0]   saida_preco,
   output logic                  erro
);

   localparam int unsigned W_PROD = W_PESO + W_PRECO;
   localparam int unsigned LIMIT  = 10**DIGITS - 1;
   localparam int unsigned W_BIN  = $clog2(LIMIT + 1);
   localparam int unsigned W_BCD  = 4 * DIGITS;
   localparam int unsigned W_CNT  = $clog2(W_PROD + 2);
   localparam logic [10:0] DIVISOR = 11'd1000;

   typedef enum logic [2:0] {StIdle, StMult, StDiv, StBcd, StHold} state_e;

   state_e              state_q, state_d;
   logic [W_CNT-1:0]    cnt_q, cnt_d;
   logic [W_PESO-1:0]   tara_q, tara_d;
   logic [W_PESO-1:0]   net_q, net_d;
   logic [W_PESO-1:0]   mplier_q, mplier_d;
   logic [W_PROD-1:0]   mcand_q, mcand_d;
   logic [W_PROD-1:0]   prod_q, prod_d;
   logic [9:0]          rem_q, rem_d;
   logic [W_BIN-1:0]    bin_peso_q, bin_peso_d, bin_preco_q, bin_preco_d;
   logic [W_BCD-1:0]    bcd_peso_q, bcd_peso_d, bcd_preco_q, bcd_preco_d;
   logic                erro_q, erro_d;
   logic [W_BCD-1:0]    saida_peso_q, saida_peso_d, saida_preco_q, saida_preco_d;
   logic                saida_erro_q, saida_erro_d;

   logic [10:0]         rem_sh;
   logic                qbit;
   logic [W_PROD-1:0]   q_nx;
   logic                q_over, net_over;
   logic [W_BCD-1:0]    bcd_peso_nx, bcd_preco_nx;

   function automatic logic [W_BCD-1:0] add3(input logic [W_BCD-1:0] b);
      logic [W_BCD-1:0] r;
      r = b;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tara_d        = tara_q;
      net_d         = net_q;
      mplier_d      = mplier_q;
      mcand_d       = mcand_q;
      prod_d        = prod_q;
      rem_d         = rem_q;
      bin_peso_d    = bin_peso_q;
      bin_preco_d   = bin_preco_q;
      bcd_peso_d    = bcd_peso_q;
      bcd_preco_d   = bcd_preco_q;
      erro_d        = erro_q;
      saida_peso_d  = saida_peso_q;
      saida_preco_d = saida_preco_q;
      saida_erro_d  = saida_erro_q;

      // During DIV the product register doubles as dividend/quotient shift register
      rem_sh   = {rem_q, prod_q[W_PROD-1]};
      qbit     = (rem_sh >= DIVISOR);
      q_nx     = {prod_q[W_PROD-2:0], qbit};
      q_over   = (q_nx > W_PROD'(LIMIT));
      net_over = (32'(net_q) > LIMIT);

      bcd_peso_nx  = {add3(bcd_peso_q)[W_BCD-2:0], bin_peso_q[W_BIN-1]};
      bcd_preco_nx = {add3(bcd_preco_q)[W_BCD-2:0], bin_preco_q[W_BIN-1]};

      case (state_q)
         StIdle: begin
            if (tara_btn) begin
               tara_d = peso_g;
            end else if (start) begin
               net_d    = (peso_g >= tara_q) ? peso_g - tara_q : '0;
               mplier_d = (peso_g >= tara_q) ? peso_g - tara_q : '0;
               mcand_d  = W_PROD'(preco_kg);
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = StMult;
            end
         end
         StMult: begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q + W_CNT'(1);
            if (cnt_q == W_CNT'(W_PESO - 1)) begin
               cnt_d   = '0;
               state_d = StDiv;
            end
         end
         StDiv: begin
            if (cnt_q == '0) begin
               // Half-up rounding; cannot carry out since the max product leaves ample headroom
               prod_d = prod_q + W_PROD'(500);
               rem_d  = '0;
               cnt_d  = W_CNT'(1);
            end else begin
               prod_d = q_nx;
               rem_d  = qbit ? 10'(rem_sh - DIVISOR) : rem_sh[9:0];
               cnt_d  = cnt_q + W_CNT'(1);
               if (cnt_q == W_CNT'(W_PROD)) begin
                  bin_preco_d = q_over ? W_BIN'(LIMIT) : q_nx[W_BIN-1:0];
                  bin_peso_d  = net_over ? W_BIN'(LIMIT) : W_BIN'(net_q);
                  erro_d      = q_over | net_over;
                  bcd_peso_d  = '0;
                  bcd_preco_d = '0;
                  cnt_d       = '0;
                  state_d     = StBcd;
               end
            end
         end
         StBcd: begin
            bcd_peso_d  = bcd_peso_nx;
            bcd_preco_d = bcd_preco_nx;
            bin_peso_d  = bin_peso_q << 1;
            bin_preco_d = bin_preco_q << 1;
            cnt_d       = cnt_q + W_CNT'(1);
            if (cnt_q == W_CNT'(W_BIN - 1)) begin
               saida_peso_d  = bcd_peso_nx;
               saida_preco_d = bcd_preco_nx;
               saida_erro_d  = erro_q;
               cnt_d         = '0;
               state_d       = StHold;
            end
         end
         StHold: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         tara_q        <= '0;
         net_q         <= '0;
         mplier_q      <= '0;
         mcand_q       <= '0;
         prod_q        <= '0;
         rem_q         <= '0;
         bin_peso_q    <= '0;
         bin_preco_q   <= '0;
         bcd_peso_q    <= '0;
         bcd_preco_q   <= '0;
         erro_q        <= 1'b0;
         saida_peso_q  <= '0;
         saida_preco_q <= '0;
         saida_erro_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tara_q        <= tara_d;
         net_q         <= net_d;
         mplier_q      <= mplier_d;
         mcand_q       <= mcand_d;
         prod_q        <= prod_d;
         rem_q         <= rem_d;
         bin_peso_q    <= bin_peso_d;
         bin_preco_q   <= bin_preco_d;
         bcd_peso_q    <= bcd_peso_d;
         bcd_preco_q   <= bcd_preco_d;
         erro_q        <= erro_d;
         saida_peso_q  <= saida_peso_d;
         saida_preco_q <= saida_preco_d;
         saida_erro_q  <= saida_erro_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign out_valid   = (state_q == StHold);
   assign saida_peso  = saida_peso_q;
   assign saida_preco = saida_preco_q;
   assign erro        = saida_erro_q;

endmodule

// File: tb/tb_balanca_ctrl.sv
// Directed bench for balanca_ctrl: reset, pricing, tare, rounding, clamp, handshake, mid-op reset.
module tb_balanca_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] peso_g = '0;
   logic [15:0] preco_kg = '0;
   logic        tara_btn = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic        busy, out_valid, erro;
   logic [23:0] saida_peso, saida_preco;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   balanca_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .peso_g      (peso_g),
      .preco_kg    (preco_kg),
      .tara_btn    (tara_btn),
      .start       (start),
      .out_ready   (out_ready),
      .busy        (busy),
      .out_valid   (out_valid),
      .saida_peso  (saida_peso),
      .saida_preco (saida_preco),
      .erro        (erro)
   );

   task automatic pulse_tare(input logic [19:0] p);
      @(negedge clk); peso_g = p; tara_btn = 1'b1;
      @(posedge clk); #1 tara_btn = 1'b0;
   endtask

   // Returns cycles from the start-sampling edge to out_valid, or -1 on timeout
   task automatic run_calc(input logic [19:0] p, input logic [15:0] c, output int lat);
      @(negedge clk); peso_g = p; preco_kg = c; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = n; break; end
      end
   endtask

   task automatic accept();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
      checks++; if (saida_peso !== 24'h0) begin errors++; $display("FAIL rst_peso got %h want 000000", saida_peso); end
      checks++; if (saida_preco !== 24'h0) begin errors++; $display("FAIL rst_preco got %h want 000000", saida_preco); end
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL rst_erro got %b want 0", erro); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      run_calc(20'd1500, 16'd299, lat);
      checks++; if (lat !== 77) begin errors++; $display("FAIL t1_latency got %0d want 77", lat); end
      checks++; if (saida_peso !== 24'h001500) begin errors++; $display("FAIL t1_peso got %h want 001500", saida_peso); end
      checks++; if (saida_preco !== 24'h000449) begin errors++; $display("FAIL t1_preco got %h want 000449", saida_preco); end
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL t1_erro got %b want 0", erro); end
      accept();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_release got valid=%b busy=%b want 0 0", out_valid, busy); end
      checks++; if (saida_preco !== 24'h000449) begin errors++; $display("FAIL t1_keep got %h want 000449", saida_preco); end
   endtask

   task automatic test_tare();
      int lat;
      pulse_tare(20'd200);
      run_calc(20'd1200, 16'd1000, lat);
      checks++; if (saida_peso !== 24'h001000) begin errors++; $display("FAIL t2_peso got %h want 001000", saida_peso); end
      checks++; if (saida_preco !== 24'h001000) begin errors++; $display("FAIL t2_preco got %h want 001000", saida_preco); end
      accept();
      run_calc(20'd150, 16'd1000, lat);
      checks++; if (saida_peso !== 24'h0 || saida_preco !== 24'h0) begin errors++; $display("FAIL t2_neg got %h %h want 000000 000000", saida_peso, saida_preco); end
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL t2_erro got %b want 0", erro); end
      accept();
      pulse_tare(20'd0);
   endtask

   task automatic test_rounding();
      int lat;
      run_calc(20'd1, 16'd499, lat);
      checks++; if (saida_preco !== 24'h000000) begin errors++; $display("FAIL t3_499 got %h want 000000", saida_preco); end
      accept();
      run_calc(20'd1, 16'd500, lat);
      checks++; if (saida_preco !== 24'h000001) begin errors++; $display("FAIL t3_500 got %h want 000001", saida_preco); end
      accept();
      run_calc(20'd3, 16'd500, lat);
      checks++; if (saida_preco !== 24'h000002) begin errors++; $display("FAIL t3_1500 got %h want 000002", saida_preco); end
      accept();
   endtask

   task automatic test_clamp();
      int lat;
      run_calc(20'd1048575, 16'd65535, lat);
      checks++; if (saida_peso !== 24'h999999) begin errors++; $display("FAIL t4_peso got %h want 999999", saida_peso); end
      checks++; if (saida_preco !== 24'h999999) begin errors++; $display("FAIL t4_preco got %h want 999999", saida_preco); end
      checks++; if (erro !== 1'b1) begin errors++; $display("FAIL t4_erro got %b want 1", erro); end
      accept();
      // 999999 g at 1 c/kg: no clamp, total rounds to 1000
      run_calc(20'd999999, 16'd1, lat);
      checks++; if (saida_peso !== 24'h999999 || saida_preco !== 24'h001000 || erro !== 1'b0) begin
         errors++; $display("FAIL t4_edge got %h %h %b want 999999 001000 0", saida_peso, saida_preco, erro); end
      accept();
      // net alone over the limit
      run_calc(20'd1000000, 16'd0, lat);
      checks++; if (saida_peso !== 24'h999999 || saida_preco !== 24'h0 || erro !== 1'b1) begin
         errors++; $display("FAIL t4_net got %h %h %b want 999999 000000 1", saida_peso, saida_preco, erro); end
      accept();
      run_calc(20'd1500, 16'd299, lat);
      checks++; if (erro !== 1'b0 || saida_preco !== 24'h000449) begin errors++; $display("FAIL t4_recover got %b %h want 0 000449", erro, saida_preco); end
      accept();
   endtask

   task automatic test_handshake();
      int lat;
      @(negedge clk); peso_g = 20'd1500; preco_kg = 16'd299; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         start = 1'b0; tara_btn = 1'b0;
         if (out_valid) begin lat = n; break; end
         if (n == 10 || n == 40 || n == 65) begin peso_g = 20'd500; start = 1'b1; tara_btn = 1'b1; end
      end
      checks++; if (lat !== 77) begin errors++; $display("FAIL t5_latency got %0d want 77", lat); end
      peso_g = 20'd500; start = 1'b1; tara_btn = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         start = 1'b0; tara_btn = 1'b0;
         checks++; if (out_valid !== 1'b1 || saida_peso !== 24'h001500 || saida_preco !== 24'h000449) begin
            errors++; $display("FAIL t5_hold got %b %h %h want 1 001500 000449", out_valid, saida_peso, saida_preco); end
      end
      accept();
      run_calc(20'd500, 16'd1000, lat);
      checks++; if (saida_peso !== 24'h000500 || saida_preco !== 24'h000500) begin
         errors++; $display("FAIL t5_notare got %h %h want 000500 000500", saida_peso, saida_preco); end
      accept();
      @(negedge clk); peso_g = 20'd300; tara_btn = 1'b1; start = 1'b1;
      @(posedge clk); #1 tara_btn = 1'b0; start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_tarewins got busy=%b want 0", busy); end
      run_calc(20'd300, 16'd1000, lat);
      checks++; if (saida_peso !== 24'h0) begin errors++; $display("FAIL t5_taregot got %h want 000000", saida_peso); end
      accept();
      pulse_tare(20'd0);
   endtask

   task automatic test_reset_mid();
      int lat;
      pulse_tare(20'd100);
      @(negedge clk); peso_g = 20'd1500; preco_kg = 16'd299; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t6_state got busy=%b valid=%b want 0 0", busy, out_valid); end
      checks++; if (saida_peso !== 24'h0 || saida_preco !== 24'h0 || erro !== 1'b0) begin
         errors++; $display("FAIL t6_outs got %h %h %b want 000000 000000 0", saida_peso, saida_preco, erro); end
      run_calc(20'd1500, 16'd299, lat);
      checks++; if (lat !== 77) begin errors++; $display("FAIL t6_latency got %0d want 77", lat); end
      checks++; if (saida_peso !== 24'h001500) begin errors++; $display("FAIL t6_tare got %h want 001500", saida_peso); end
      accept();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tare();
      test_rounding();
      test_clamp();
      test_handshake();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
